// File: rtl/uart_transmitter.sv
// UART transmitter: start bit, DATA_BITS data bits, optional even parity, STOP_BITS stop bits.
// Define UART_TX_PARITY_EN to insert the parity bit between the data and stop bits.
module uart_transmitter #(
  parameter int CLKS_PER_BIT = 1,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter bit MSB_FIRST    = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_serial,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] CPB_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
  localparam bit ONE_CLK_BIT    = (CLKS_PER_BIT == 1);
  localparam bit STOP_ONE_CYCLE = (CLKS_PER_BIT == 1) && (STOP_BITS == 1);
`ifdef UART_TX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                 state_reg;
  logic [CW-1:0]          clk_cnt_reg;
  logic [BW-1:0]          bit_cnt_reg;
  logic [DATA_BITS-1:0]   shift_reg;
  logic                   tx_serial_reg;
  logic                   busy_reg;
  logic                   done_reg;

  logic [DATA_BITS-1:0]   ordered;
  logic [BW-1:0]          sel_idx;
  logic                   next_bit;
  logic                   bit_end;
  logic                   stop_last;
  logic                   accept;

  // Reorder the latched byte into transmission order so the bit counter indexes it directly.
  for (genvar gi = 0; gi < DATA_BITS; gi++) begin : g_order
    if (MSB_FIRST) begin : g_msb
      assign ordered[gi] = shift_reg[DATA_BITS-1-gi];
    end else begin : g_lsb
      assign ordered[gi] = shift_reg[gi];
    end
  end

  always_comb begin
    sel_idx  = (state_reg == DATA) ? bit_cnt_reg + 1'b1 : '0;
    next_bit = 1'b0;
    for (int i = 0; i < DATA_BITS; i++) begin
      if (sel_idx == BW'(i)) next_bit = ordered[i];
    end
  end

  assign bit_end   = (clk_cnt_reg == CPB_LAST);
  assign stop_last = (state_reg == STOP) && bit_end && (bit_cnt_reg == STOP_LAST);
  assign tx_ready  = !rst && ((state_reg == IDLE) || stop_last);
  assign accept    = tx_valid && tx_ready;

  assign tx_serial = tx_serial_reg;
  assign tx_busy   = busy_reg;
  assign tx_done   = done_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      clk_cnt_reg   <= '0;
      bit_cnt_reg   <= '0;
      shift_reg     <= '0;
      tx_serial_reg <= 1'b1;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (accept) begin
        shift_reg     <= tx_data;
        state_reg     <= START;
        tx_serial_reg <= 1'b0;
        busy_reg      <= 1'b1;
        clk_cnt_reg   <= '0;
        bit_cnt_reg   <= '0;
      end else begin
        case (state_reg)
          IDLE: tx_serial_reg <= 1'b1;
          START: begin
            if (bit_end) begin
              clk_cnt_reg   <= '0;
              state_reg     <= DATA;
              tx_serial_reg <= next_bit;
            end else begin
              clk_cnt_reg <= clk_cnt_reg + 1'b1;
            end
          end
          DATA: begin
            if (bit_end) begin
              clk_cnt_reg <= '0;
              if (bit_cnt_reg == DATA_LAST) begin
                bit_cnt_reg <= '0;
                if (PAR_EN) begin
                  state_reg     <= PARITY;
                  tx_serial_reg <= ^shift_reg;
                end else begin
                  state_reg     <= STOP;
                  tx_serial_reg <= 1'b1;
                  done_reg      <= STOP_ONE_CYCLE;
                end
              end else begin
                bit_cnt_reg   <= bit_cnt_reg + 1'b1;
                tx_serial_reg <= next_bit;
              end
            end else begin
              clk_cnt_reg <= clk_cnt_reg + 1'b1;
            end
          end
          PARITY: begin
            if (bit_end) begin
              clk_cnt_reg   <= '0;
              state_reg     <= STOP;
              tx_serial_reg <= 1'b1;
              done_reg      <= STOP_ONE_CYCLE;
            end else begin
              clk_cnt_reg <= clk_cnt_reg + 1'b1;
            end
          end
          STOP: begin
            // done is registered, so it is raised one edge ahead of the final stop cycle.
            if (stop_last) begin
              state_reg <= IDLE;
              busy_reg  <= 1'b0;
            end else if (bit_end) begin
              clk_cnt_reg <= '0;
              bit_cnt_reg <= bit_cnt_reg + 1'b1;
              done_reg    <= ONE_CLK_BIT && (bit_cnt_reg + 1'b1 == STOP_LAST);
            end else begin
              clk_cnt_reg <= clk_cnt_reg + 1'b1;
              done_reg    <= (clk_cnt_reg + 1'b1 == CPB_LAST) && (bit_cnt_reg == STOP_LAST);
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: three configurations driven in parallel, each checked every cycle
// against a frame-level line model, plus literal waveform checks on selected channels.
module tb_uart_transmitter;

  localparam int N = 3;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [7:0]   tx_data;
  logic [N-1:0] valid;
  logic [N-1:0] ready, ser, busy, done;

  int n_checks = 0;
  int n_fail   = 0;
  int acc_cnt [N];
  bit m_busy  [N];

  logic [63:0] rec, drec;
  int rec_n, rec_len, rec_ch, done_cnt, busy_cnt;

  task automatic check(input string name, input int chn, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s ch%0d: got %0h, expected %0h at t=%0t", name, chn, act, exp, $time);
    end
  endtask

  // ch0: 1 clk/bit MSB-first; ch1: 4 clk/bit MSB-first; ch2: 2 clk/bit, 5 bits, LSB-first, 2 stops
  for (genvar gi = 0; gi < N; gi++) begin : ch
    localparam int CPB = (gi == 0) ? 1 : (gi == 1) ? 4 : 2;
    localparam int DB  = (gi == 2) ? 5 : 8;
    localparam int SB  = (gi == 2) ? 2 : 1;
    localparam bit MSB = (gi != 2);

    uart_transmitter #(
      .CLKS_PER_BIT(CPB), .DATA_BITS(DB), .STOP_BITS(SB), .MSB_FIRST(MSB)
    ) dut (
      .clk(clk), .rst(rst), .tx_data(tx_data[DB-1:0]), .tx_valid(valid[gi]),
      .tx_ready(ready[gi]), .tx_serial(ser[gi]), .tx_busy(busy[gi]), .tx_done(done[gi])
    );

    // Expected line level for every future cycle; front = the current cycle.
    bit line_q [$];
    bit take, v;
    bit e_ser, e_ready, e_busy, e_done;

    always @(posedge clk) begin
      if (rst) begin
        line_q.delete();
      end else begin
        take = valid[gi] && (line_q.size() <= 1);
        if (line_q.size() > 0) void'(line_q.pop_front());
        if (take) begin
          acc_cnt[gi]++;
          for (int b = 0; b < 1 + DB + PAR + SB; b++) begin
            if (b == 0)                      v = 1'b0;
            else if (b <= DB)                v = MSB ? tx_data[DB-b] : tx_data[b-1];
            else if (PAR == 1 && b == DB+1)  v = ^tx_data[DB-1:0];
            else                             v = 1'b1;
            repeat (CPB) line_q.push_back(v);
          end
        end
      end
      m_busy[gi] = (line_q.size() != 0);
    end

    always @(negedge clk) begin
      e_ser   = (line_q.size() == 0) ? 1'b1 : line_q[0];
      e_busy  = (line_q.size() != 0);
      e_done  = (line_q.size() == 1);
      e_ready = !rst && (line_q.size() <= 1);
      check("tx_serial", gi, 64'(ser[gi]),   64'(e_ser));
      check("tx_busy",   gi, 64'(busy[gi]),  64'(e_busy));
      check("tx_done",   gi, 64'(done[gi]),  64'(e_done));
      check("tx_ready",  gi, 64'(ready[gi]), 64'(e_ready));
    end
  end

  always @(negedge clk) begin
    if (rec_n < rec_len) begin
      rec      = {rec[62:0], ser[rec_ch]};
      drec     = {drec[62:0], done[rec_ch]};
      done_cnt += int'(done[rec_ch]);
      busy_cnt += int'(busy[rec_ch]);
      rec_n++;
    end
  end

  task automatic start_rec(input int chn, input int len);
    rec_ch = chn; rec = '0; drec = '0; rec_n = 0;
    done_cnt = 0; busy_cnt = 0; rec_len = len;
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 500; c++) begin
      if (!m_busy[0] && !m_busy[1] && !m_busy[2]) break;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  // Offer d0 to all channels (all idle), then d1, until each channel accepted n bytes.
  task automatic send(input logic [7:0] d0, input logic [7:0] d1, input int n,
                      input int rch, input int rlen);
    int base [N];
    int c;
    for (int i = 0; i < N; i++) base[i] = acc_cnt[i];
    tx_data = d0;
    valid   = '1;
    @(posedge clk); #1;
    tx_data = d1;
    start_rec(rch, rlen);
    c = 0;
    while (valid != '0 && c < 400) begin
      for (int i = 0; i < N; i++) if (acc_cnt[i] >= base[i] + n) valid[i] = 1'b0;
      if (valid != '0) begin @(posedge clk); #1; c++; end
    end
    valid = '0;
    wait (rec_n >= rec_len);
    #1;
    wait_idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; valid = '0; tx_data = '0;
    rec = '0; drec = '0; rec_n = 0; rec_len = 0; rec_ch = 0; done_cnt = 0; busy_cnt = 0;

    // T1: reset held for three edges
    @(posedge clk);
    @(negedge clk);
    check("t1_rst_ready",  0, 64'(ready[0]), 64'(0));
    check("t1_rst_serial", 0, 64'(ser[0]),   64'(1));
    check("t1_rst_busy",   0, 64'(busy[0]),  64'(0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("t1_ready", 0, 64'(ready[0]), 64'(1));
    check("t1_done",  0, 64'(done[0]),  64'(0));
    @(posedge clk); #1;

    // T2: single 0xA5 frame
`ifdef UART_TX_PARITY_EN
    send(8'hA5, 8'hA5, 1, 0, 11);
    check("t2_line", 0, rec,  64'(11'b0_10100101_0_1));
    check("t2_done", 0, drec, 64'(11'b00000000001));
`else
    send(8'hA5, 8'hA5, 1, 0, 10);
    check("t2_line", 0, rec,  64'(10'b0_10100101_1));
    check("t2_done", 0, drec, 64'(10'b0000000001));
`endif

    // T3: back-to-back 0x3C then 0xC3 with valid held
`ifdef UART_TX_PARITY_EN
    send(8'h3C, 8'hC3, 2, 0, 22);
    check("t3_line", 0, rec, 64'(22'b0_00111100_0_1_0_11000011_0_1));
`else
    send(8'h3C, 8'hC3, 2, 0, 20);
    check("t3_line", 0, rec, 64'(20'b0_00111100_1_0_11000011_1));
`endif
    check("t3_done_pulses", 0, 64'(done_cnt), 64'(2));

    // T4: 0x81 at 4 clk/bit, observed on ch1 with a few idle cycles after the frame
`ifdef UART_TX_PARITY_EN
    send(8'h81, 8'h81, 1, 1, 48);
    check("t4_line", 1, rec, 64'({4'h0, 4'hF, 24'h0, 4'hF, 4'h0, 4'hF, 4'hF}));
    check("t4_busy_cycles", 1, 64'(busy_cnt), 64'(44));
`else
    send(8'h81, 8'h81, 1, 1, 44);
    check("t4_line", 1, rec, 64'({4'h0, 4'hF, 24'h0, 4'hF, 4'hF, 4'hF}));
    check("t4_busy_cycles", 1, 64'(busy_cnt), 64'(40));
`endif
    check("t4_done_pulses", 1, 64'(done_cnt), 64'(1));

    // T5: 0x07 (odd number of ones, so the even-parity bit is 1)
`ifdef UART_TX_PARITY_EN
    send(8'h07, 8'h07, 1, 0, 11);
    check("t5_line", 0, rec,  64'(11'b0_00000111_1_1));
    check("t5_done", 0, drec, 64'(11'b00000000001));
`else
    send(8'h07, 8'h07, 1, 0, 10);
    check("t5_line", 0, rec,  64'(10'b0_00000111_1));
    check("t5_done", 0, drec, 64'(10'b0000000001));
`endif

    // T6: reset during the 4th data bit of 0xFF, then a clean 0x00 frame
    tx_data = 8'hFF;
    valid   = '1;
    @(posedge clk); #1;
    valid = '0;
    start_rec(0, 15);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t6_abort_serial", 0, 64'(ser[0]),   64'(1));
    check("t6_abort_ready",  0, 64'(ready[0]), 64'(0));
    #1 rst = 1'b0;
    @(negedge clk);
    check("t6_release_ready", 0, 64'(ready[0]), 64'(1));
    wait (rec_n >= rec_len);
    #1;
    check("t6_line",       0, rec, 64'(15'b0_11111111111111));
    check("t6_no_done",    0, 64'(done_cnt), 64'(0));
    wait_idle();
`ifdef UART_TX_PARITY_EN
    send(8'h00, 8'h00, 1, 0, 11);
    check("t6_next_line", 0, rec, 64'(11'b0_00000000_0_1));
`else
    send(8'h00, 8'h00, 1, 0, 10);
    check("t6_next_line", 0, rec, 64'(10'b0_00000000_1));
`endif
    check("t6_next_done", 0, 64'(done_cnt), 64'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
